// File: rtl/playback_pkg.sv
// Shared playback/recorder definitions: FSM encoding and default widths,
// kept in one place so the recorder and reader agree on sizes.
package playback_pkg;

    localparam int PB_ADDR_W = 16;
    localparam int PB_DATA_W = 8;
    localparam int PB_INTERP = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        WAIT  = 2'd2,
        HOLD  = 2'd3
    } state_t;

    // Width of a counter that must reach n-1; never narrower than 1 bit.
    function automatic int rep_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/playback_reader.sv
// Plays stored samples from address 0 to a latched end address, holding each
// for INTERP ready strobes. Optional macro LOOP_PLAYBACK_EN wraps to 0 forever.
module playback_reader
    import playback_pkg::*;
#(
    parameter int ADDR_W = PB_ADDR_W,
    parameter int DATA_W = PB_DATA_W,
    parameter int INTERP = PB_INTERP
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic              stop,
    input  logic [ADDR_W-1:0] end_addr,
    input  logic              ready,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [DATA_W-1:0] to_ac97_data,
    output logic              busy,
    output logic              done,
    output logic              underrun
);

    localparam int REP_W = rep_width(INTERP);
    localparam logic [REP_W-1:0] REP_LAST = REP_W'(INTERP - 1);

    state_t            state_r, state_nxt;
    logic [ADDR_W-1:0] addr_r, end_r;
    logic [REP_W-1:0]  rep_r;
    logic [DATA_W-1:0] sample_r, out_r;
    logic              valid_r, done_r, underrun_r;

    logic accept, abort, fire, last_rep, last_addr;

    assign accept    = (state_r == IDLE) && start && !stop;
    assign abort     = (state_r != IDLE) && stop;
    assign fire      = (state_r == HOLD) && ready && valid_r;
    assign last_rep  = (rep_r == REP_LAST);
    assign last_addr = (addr_r == end_r);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) state_r <= IDLE;
        else        state_r <= state_nxt;
    end

    always_comb begin
        state_nxt = state_r;
        case (state_r)
            IDLE:    if (accept) state_nxt = FETCH;
            FETCH:   state_nxt = WAIT;
            WAIT:    state_nxt = HOLD;
            HOLD: begin
                if (fire && last_rep) begin
`ifdef LOOP_PLAYBACK_EN
                    state_nxt = FETCH;
`else
                    state_nxt = last_addr ? IDLE : FETCH;
`endif
                end
            end
            default: state_nxt = IDLE;
        endcase
        if (abort) state_nxt = IDLE;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            addr_r     <= '0;
            end_r      <= '0;
            rep_r      <= '0;
            sample_r   <= '0;
            out_r      <= '0;
            valid_r    <= 1'b0;
            done_r     <= 1'b0;
            underrun_r <= 1'b0;
        end else begin
            done_r <= 1'b0;
            if (state_r == IDLE) begin
                out_r <= '0;
                if (accept) begin
                    end_r      <= end_addr;
                    addr_r     <= '0;
                    rep_r      <= '0;
                    valid_r    <= 1'b0;
                    underrun_r <= 1'b0;
                end
            end else if (stop) begin
                // abort: mute immediately, leave counters for the next start to reset
                out_r   <= '0;
                valid_r <= 1'b0;
            end else begin
                if (state_r == WAIT) begin
                    sample_r <= mem_rdata;
                    valid_r  <= 1'b1;
                end
                if (ready && !valid_r) underrun_r <= 1'b1;
                if (fire) begin
                    out_r <= sample_r;
                    if (last_rep) begin
                        rep_r   <= '0;
                        valid_r <= 1'b0;
                        if (last_addr) begin
                            done_r <= 1'b1;
`ifdef LOOP_PLAYBACK_EN
                            addr_r <= '0;
`endif
                        end else begin
                            addr_r <= addr_r + ADDR_W'(1);
                        end
                    end else begin
                        rep_r <= rep_r + REP_W'(1);
                    end
                end
            end
        end
    end

    assign mem_addr     = addr_r;
    assign to_ac97_data = out_r;
    assign busy         = (state_r != IDLE);
    assign done         = done_r;
    assign underrun     = underrun_r;

endmodule

// File: doc/playback_reader.md
Name: playback_reader

Overview:
- Read-side counterpart of the recorder's capture path.
- Walks sample memory from address 0 to a latched end address.
- Fetches each stored 8-bit sample and presents it on to_ac97_data.
- Holds each sample for INTERP consecutive AC97 ready strobes, restoring the 48 kHz rate from the decimated store.
- Sits between the sample BRAM (read port) and the AC97 output data path.

Parameters:
- ADDR_W, 16, sample memory address width.
- DATA_W, 8, sample width; two's complement.
- INTERP, 8, number of ready strobes each stored sample is held (>=1).

Ports:
- clock  input  1  system clock.
- reset  input  1  asynchronous, active-low reset.
- start  input  1  one-cycle pulse; begin playback from address 0.
- stop  input  1  one-cycle pulse; abort playback.
- end_addr  input  ADDR_W  last valid address written by recorder; latched on accepted start.
- ready  input  1  one-cycle AC97 sample strobe (~48 kHz, >=4 clocks apart).
- mem_addr  output  ADDR_W  BRAM read address.
- mem_rdata  input  DATA_W  BRAM read data; valid exactly 1 clock after mem_addr.
- to_ac97_data  output  DATA_W  sample to codec.
- busy  output  1  high while not IDLE.
- done  output  1  one-cycle pulse when playback completes.
- underrun  output  1  sticky; set when ready arrives with no valid sample.

Behaviour:
- Reset (reset low, async):
  - state=IDLE; mem_addr=0; to_ac97_data=0; busy=0; done=0; underrun=0; rep count=0; sample valid=0.
- IDLE:
  - to_ac97_data forced 0 (mute).
  - start accepted: end_addr latched to end_r, addr=0, rep=0, underrun cleared, next state FETCH.
- FETCH: mem_addr=addr; next WAIT.
- WAIT: capture mem_rdata into sample_r; valid=1; next HOLD.
  - Fetch latency is 2 clocks from entering FETCH to valid sample.
- HOLD, on ready:
  - to_ac97_data <= sample_r (registered; updates the clock after ready).
  - If rep==INTERP-1:
    - rep=0; valid=0.
    - If addr==end_r: done pulse, state IDLE.
    - Else addr=addr+1, state FETCH.
  - Otherwise rep=rep+1.
- ready while in FETCH/WAIT (valid=0):
  - to_ac97_data holds its previous value; underrun set; rep not advanced.
- stop in any non-IDLE state: state IDLE next cycle, to_ac97_data=0, no done pulse.
- start while busy: ignored.
- start and stop in the same cycle: stop wins (IDLE stays IDLE).
- end_addr=0: one sample played INTERP times, then done.
- Address arithmetic is unsigned ADDR_W; addr never exceeds end_r.
- done and ready coincident with start in IDLE: start accepted normally.
- reset asserted mid-playback: immediate return to reset values; no done.

Optional Feature:
- Macro LOOP_PLAYBACK_EN.
- Defined: at rep==INTERP-1 with addr==end_r, addr wraps to 0 and state goes to FETCH. done pulses once per pass; busy stays high until stop.
- Undefined: playback ends at end_r with done and returns to IDLE as above.

Decomposition:
- Shared package playback_pkg holds:
  - State encoding IDLE/FETCH/WAIT/HOLD (2-bit).
  - Default ADDR_W, DATA_W, INTERP constants, shared with recorder so widths match.
- No sub-module needed.
- The rep/addr counters stay inline; the FSM plus counters fit in one module.

Test Plan:
- Memory preloaded 0x10,0x20,0x30; end_addr=2; start; ready every 10 clocks -> to_ac97_data = 0x10 for 8 strobes, 0x20 for 8, 0x30 for 8; done pulse after the 24th strobe; busy falls.
- end_addr=0, memory[0]=0x80 -> output 0x80 (-128) for 8 strobes, then done, then output 0.
- stop asserted after 5th strobe of sample 1 -> next cycle busy=0, to_ac97_data=0, no done.
- ready issued 1 clock after start (during FETCH) -> underrun=1, output stays 0; next ready after WAIT outputs mem[0].
- start and stop in the same cycle from IDLE -> busy stays 0; second start while busy -> addr unaffected.
- With LOOP_PLAYBACK_EN, end_addr=1, mem=0x05,0x06 -> sequence 0x05×8, 0x06×8, 0x05×8…; done pulses every 16 strobes; reset low mid-run -> all outputs 0 asynchronously.
